// File: rtl/lfsr_gen_pkg.sv
// rtl/lfsr_gen_pkg.sv - mode encodings and default Galois feedback masks for lfsr_gen
package lfsr_gen_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_LFSR = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  // Maximal-length Galois masks for the commonly used widths
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

endpackage

// File: rtl/lfsr_gen_if.sv
// rtl/lfsr_gen_if.sv - control/status bundle for lfsr_gen; period appears with LFSR_GEN_PERIOD_CNT_EN
interface lfsr_gen_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             wrap;
  logic             lockup;
`ifdef LFSR_GEN_PERIOD_CNT_EN
  logic [WIDTH:0]   period;

  modport master (output en, mode, load, load_val, input out, wrap, lockup, period);
  modport slave  (input en, mode, load, load_val, output out, wrap, lockup, period);
`else
  modport master (output en, mode, load, load_val, input out, wrap, lockup);
  modport slave  (input en, mode, load, load_val, output out, wrap, lockup);
`endif

endinterface

// File: rtl/lfsr_gen_next.sv
// rtl/lfsr_gen_next.sv - combinational next-state, wrap candidate and zero-lock detect
module lfsr_gen_next
  import lfsr_gen_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] start,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next,
  output logic             wrap_cand,
  output logic             zero_lock
);

  always_comb begin
    next      = state;
    wrap_cand = 1'b0;
    zero_lock = 1'b0;
    case (mode)
      MODE_UP: begin
        next      = state + WIDTH'(1);
        wrap_cand = (next == '0);
      end
      MODE_DOWN: begin
        next      = state - WIDTH'(1);
        wrap_cand = (next == '1);
      end
      MODE_LFSR: begin
        // All-zero is a fixed point of the shift, so recover to the seed instead
        if (state == '0) begin
          next      = SEED;
          zero_lock = 1'b1;
        end else begin
          next      = (state >> 1) ^ (state[0] ? TAPS : '0);
          wrap_cand = (next == start);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - up/down/Galois-LFSR/hold pattern generator; LFSR_GEN_PERIOD_CNT_EN adds period measurement
module lfsr_gen
  import lfsr_gen_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic      clk,
  input  logic      rst,
  lfsr_gen_if.slave bus
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] nxt;
  logic             wrap_cand;
  logic             zero_lock;
  logic             wrap_q;
  logic             lockup_q;
  logic             step;

  lfsr_gen_next #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_next (
    .state     (state),
    .start     (start),
    .mode      (bus.mode),
    .next      (nxt),
    .wrap_cand (wrap_cand),
    .zero_lock (zero_lock)
  );

  assign step = bus.en && (bus.mode != MODE_HOLD);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= SEED;
      start    <= SEED;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else if (bus.load) begin
      state    <= bus.load_val;
      start    <= bus.load_val;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else if (step) begin
      state    <= nxt;
      wrap_q   <= wrap_cand;
      lockup_q <= zero_lock;
    end else begin
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end
  end

  assign bus.out    = state;
  assign bus.wrap   = wrap_q;
  assign bus.lockup = lockup_q;

`ifdef LFSR_GEN_PERIOD_CNT_EN
  logic [WIDTH:0] cnt;
  logic [WIDTH:0] period_q;

  // The count includes the wrapping step, hence +1 when it is latched
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      period_q <= '0;
    end else if (bus.load) begin
      cnt <= '0;
    end else if (step) begin
      if (wrap_cand) begin
        period_q <= cnt + (WIDTH+1)'(1);
        cnt      <= '0;
      end else if (zero_lock) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + (WIDTH+1)'(1);
      end
    end
  end

  assign bus.period = period_q;
`endif

endmodule
